// File: rtl/kv_fifo_pkg.sv
// Shared definitions for the SRL FIFO read-side drain engine.
// Holds the occupancy FSM encoding and the accepted-word counter width.
package kv_fifo_pkg;

  typedef enum logic [1:0] {
    RDR_EMPTY = 2'd0,
    RDR_ONE   = 2'd1,
    RDR_TWO   = 2'd2
  } rdr_state_e;

  localparam int CNT_W = 32;

endpackage : kv_fifo_pkg

// File: rtl/kv_srl_fifo_rdr_if.sv
// Valid/ready stream carrying words drained from the SRL FIFO.
// The master drives data/valid; the slave returns ready.
interface kv_srl_fifo_rdr_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface : kv_srl_fifo_rdr_if

// File: rtl/kv_skid2.sv
// Two-entry skid buffer: head register drives the stream, skid register absorbs
// the one word popped in the cycle the consumer stalls.
module kv_skid2
  import kv_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] pop_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output rdr_state_e       state_o
);

  rdr_state_e       state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             valid_q;
  logic             take;

  assign take = valid_q && ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RDR_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        RDR_EMPTY: begin
          if (pop_i) begin
            head_q  <= pop_data_i;
            state_q <= RDR_ONE;
            valid_q <= 1'b1;
          end
        end
        RDR_ONE: begin
          if (pop_i && !take) begin
            skid_q  <= pop_data_i;
            state_q <= RDR_TWO;
          end else if (pop_i && take) begin
            // Replace the departing head in place so a streaming flow has no bubble.
            head_q  <= pop_data_i;
          end else if (take) begin
            state_q <= RDR_EMPTY;
            valid_q <= 1'b0;
          end
        end
        RDR_TWO: begin
          if (take) begin
            head_q  <= skid_q;
            state_q <= RDR_ONE;
          end
        end
        default: begin
          state_q <= RDR_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

endmodule : kv_skid2

// File: rtl/kv_srl_fifo_rdr.sv
// Read-side drain engine for kv_srl_fifo: pops into a 2-entry skid buffer and
// streams out on valid/ready. Define KV_SRL_RDR_CNT_EN to add the m_count port.
module kv_srl_fifo_rdr
  import kv_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  kv_srl_fifo_rdr_if.master    m
`ifdef KV_SRL_RDR_CNT_EN
  ,
  output logic [CNT_W-1:0]     m_count
`endif
);

  rdr_state_e       state;
  logic [WIDTH-1:0] head;
  logic             valid;

  // Pop decision depends only on registered state and the FIFO flag, never on m_ready.
  assign fifo_rd_en = rst_n && !fifo_empty && (state != RDR_TWO);

  kv_skid2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop_i      (fifo_rd_en),
    .pop_data_i (fifo_q),
    .ready_i    (m.m_ready),
    .head_o     (head),
    .valid_o    (valid),
    .state_o    (state)
  );

  assign m.m_data  = head;
  assign m.m_valid = valid;

`ifdef KV_SRL_RDR_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid && m.m_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m_count = cnt_q;
`endif

endmodule : kv_srl_fifo_rdr

// File: tb/tb_kv_srl_fifo_rdr.sv
// Randomized bench for kv_srl_fifo_rdr against an occupancy/queue reference model
// plus a queue-based FIFO model; optional counter checks under KV_SRL_RDR_CNT_EN.
module tb_kv_srl_fifo_rdr;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] fifo_q;
  logic         fifo_empty;
  logic         fifo_rd_en;
`ifdef KV_SRL_RDR_CNT_EN
  logic [31:0]  m_count;
`endif

  kv_srl_fifo_rdr_if #(.WIDTH(W)) m_if ();

  always #5 clk = ~clk;

  kv_srl_fifo_rdr #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m          (m_if)
`ifdef KV_SRL_RDR_CNT_EN
    ,
    .m_count    (m_count)
`endif
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] fq[$];   // FIFO contents, head at index 0
  logic [W-1:0] oq[$];   // words popped but not yet accepted, oldest first
  logic [31:0]  cnt_ref = 0;
  int           n_take = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_q     = (fq.size() == 0) ? '0 : fq[0];
  endtask

  // One clock cycle: apply inputs, check against the model, clock, update the model.
  task automatic cycle(input bit rdy, input bit push, input logic [W-1:0] pv, input bit rst);
    bit exp_rd, pop, take;
    rst_n         = !rst;
    m_if.m_ready  = rdy;
    #1;
    exp_rd = !rst && (fq.size() != 0) && (oq.size() < 2);
    chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    chk("valid", {31'd0, m_if.m_valid}, {31'd0, oq.size() != 0});
    if (oq.size() != 0) chk("data", {24'd0, m_if.m_data}, {24'd0, oq[0]});
    chk("underflow", {31'd0, fifo_rd_en && (fq.size() == 0)}, 32'd0);
`ifdef KV_SRL_RDR_CNT_EN
    chk("count", m_count, cnt_ref);
`endif
    pop  = fifo_rd_en && (fq.size() != 0);
    take = m_if.m_valid && rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      oq.delete();
      cnt_ref = 0;
    end else if (take && oq.size() != 0) begin
      void'(oq.pop_front());
      cnt_ref++;
      n_take++;
    end
    if (pop) begin
      logic [W-1:0] w;
      w = fq.pop_front();
      if (!rst) oq.push_back(w);
    end
    if (push) fq.push_back(pv);
    drive_fifo();
  endtask

  task automatic drain(input bit toggle, input int bound);
    int k = 0;
    while ((fq.size() != 0 || oq.size() != 0) && k < bound) begin
      cycle(toggle ? k[0] : 1'b1, 1'b0, '0, 1'b0);
      k++;
    end
    chk("drain_timeout", {31'd0, k < bound}, 32'd1);
  endtask

  initial begin
    int c0;
    rst_n        = 1'b0;
    m_if.m_ready = 1'b0;
    drive_fifo();
    @(posedge clk);
    #1;

    // Reset state
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("rst_data", {24'd0, m_if.m_data}, 32'd0);
    chk("rst_valid", {31'd0, m_if.m_valid}, 32'd0);

    // Basic drain: 31 words at full rate in 32 cycles
    for (int i = 0; i < 31; i++) fq.push_back(W'(8'h80 + i));
    drive_fifo();
    c0 = n_take;
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    chk("drain_words", n_take - c0, 31);
    chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
    cycle(1'b1, 1'b0, '0, 1'b0);

    // Backpressure: two words buffered, pops stop, head stable
    fq.push_back(8'h10); fq.push_back(8'h11); fq.push_back(8'h12);
    drive_fifo();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("bp_data", {24'd0, m_if.m_data}, 32'h10);
    chk("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("bp_fifo_left", fq.size(), 1);
    drain(1'b0, 20);

    // Half-rate consumer while streaming 0..15
    c0 = n_take;
    for (int i = 0; i < 16; i++) cycle(i[0] == 1'b0, 1'b1, W'(i), 1'b0);
    drain(1'b1, 60);
    chk("half_words", n_take - c0, 16);

    // Empty behaviour
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0);

    // Reset mid-operation with two words buffered
    fq.push_back(8'h21); fq.push_back(8'h22); fq.push_back(8'h23);
    drive_fifo();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("rst_mid_valid", {31'd0, m_if.m_valid}, 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("rst_mid_next", {24'd0, m_if.m_data}, 32'h23);
    drain(1'b0, 20);

    // Counter: 40 transfers after a reset
    cycle(1'b1, 1'b0, '0, 1'b1);
    c0 = n_take;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, W'($urandom), 1'b0);
    drain(1'b0, 20);
    chk("forty_words", n_take - c0, 40);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit rdy, psh, rs;
      rdy = ($urandom_range(0, 3) != 0);
      psh = ($urandom_range(0, 2) != 0) && (fq.size() < 16);
      rs  = ($urandom_range(0, 299) == 0);
      cycle(rdy, psh, W'($urandom), rs);
    end
    drain(1'b0, 60);

`ifdef KV_SRL_RDR_CNT_EN
    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    cnt_ref = 32'hFFFF_FFFF;
    fq.push_back(8'h5A);
    drive_fifo();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("count_wrap", m_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_kv_srl_fifo_rdr
